// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line, read acknowledge,
// received word and status flags.
interface uart_rx_if #(
  parameter int WORD_SIZE = 8
);
  logic                 SERIAL_IN;
  logic                 READ_DONE;
  logic [WORD_SIZE-1:0] RCV_DATAREG;
  logic                 DATA_READY;
  logic                 ERR_FRAMING;
  logic                 ERR_OVERRUN;
  logic                 BUSY;

  // Driver of the line and consumer of the received data.
  modport master (
    output SERIAL_IN,
    output READ_DONE,
    input  RCV_DATAREG,
    input  DATA_READY,
    input  ERR_FRAMING,
    input  ERR_OVERRUN,
    input  BUSY
  );

  // The receiver itself.
  modport slave (
    input  SERIAL_IN,
    input  READ_DONE,
    output RCV_DATAREG,
    output DATA_READY,
    output ERR_FRAMING,
    output ERR_OVERRUN,
    output BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit 0, WORD_SIZE data bits LSB first, stop bit 1.
// Samples the mid-point of every bit, holds the last good word until the
// host acknowledges it, and reports framing and overrun errors.
module uart_rx #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic   CLOCK,
  input  logic   RESET,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(WORD_SIZE + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_SIZE-1:0] shift_reg;
  logic [WORD_SIZE-1:0] data_reg;
  logic                 data_ready;
  logic                 err_framing;
  logic                 err_overrun;
  logic                 busy;

  logic rx_meta;
  logic rx_s;
  logic rx_d;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  // NOTE: reset is synchronous here, so it sits inside the clocked branch
  // and the sensitivity list holds the clock only.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old
      // values, giving a true two-stage chain instead of a single wire.
      rx_meta <= bus.SERIAL_IN;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with counters, shift register, received word and flags.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      data_ready  <= 1'b0;
      err_framing <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
      rx_d        <= 1'b1;
    end else begin
      // rx_d only goes 1->0 via a real high-to-low edge, so a line held low
      // after a framing error (break) cannot retrigger a frame.
      rx_d <= rx_s;

      // Host acknowledge; a frame event below may override these clears.
      if (bus.READ_DONE) begin
        data_ready  <= 1'b0;
        err_overrun <= 1'b0;
        err_framing <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[WORD_SIZE-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == WORD_LAST) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              if (!data_ready || bus.READ_DONE) begin
                data_reg   <= shift_reg;
                data_ready <= 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end else begin
              err_framing <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RCV_DATAREG = data_reg;
  assign bus.DATA_READY  = data_ready;
  assign bus.ERR_FRAMING = err_framing;
  assign bus.ERR_OVERRUN = err_overrun;
  assign bus.BUSY        = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by random
// frames, compared against a frame-level model of the host-visible state.
module tb_uart_rx;

  localparam int WS  = 8;
  localparam int CPB = 16;
  // Edge index (from the cycle the start bit is driven) of the stop sample:
  // 2 synchroniser flops + 1 edge-detect cycle, half a bit, then 9 bits.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;
  localparam int RD_C      = STOP_EDGE - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference state.
  logic [WS-1:0] m_data;
  bit            m_ready;
  bit            m_ferr;
  bit            m_oerr;

  uart_rx_if #(.WORD_SIZE(WS)) bus ();

  uart_rx #(
    .WORD_SIZE   (WS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLOCK(clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s.data", tag), 32'(bus.RCV_DATAREG), 32'(m_data));
    check($sformatf("%s.ready", tag), 32'(bus.DATA_READY), 32'(m_ready));
    check($sformatf("%s.ferr", tag), 32'(bus.ERR_FRAMING), 32'(m_ferr));
    check($sformatf("%s.oerr", tag), 32'(bus.ERR_OVERRUN), 32'(m_oerr));
    check($sformatf("%s.busy", tag), 32'(bus.BUSY), 32'd0);
  endtask

  function automatic void model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    m_oerr  = 1'b0;
  endfunction

  function automatic void model_read();
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    m_oerr  = 1'b0;
  endfunction

  // Outcome of one complete frame given the stop bit and a coincident read.
  function automatic void model_frame(input logic [WS-1:0] data, input bit stop_bit,
                                      input bit rd);
    bit was_ready;
    was_ready = m_ready;
    if (rd) model_read();
    if (!stop_bit)               m_ferr = 1'b1;
    else if (was_ready && !rd)   m_oerr = 1'b1;
    else begin
      m_data  = data;
      m_ready = 1'b1;
    end
  endfunction

  // Drive one frame; optional read at the stop sample, reset pulse at
  // cycle abort_at, a low tail after the frame, and BUSY spot checks.
  task automatic send_frame(input logic [WS-1:0] data, input bit stop_bit, input bit rd_at_stop,
                            input int abort_at, input int tail_low, input bit chk_busy);
    logic [WS+1:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int c = 0; c < (WS + 2) * CPB; c++) begin
      @(posedge clk); #1;
      bus.SERIAL_IN = bits[c / CPB];
      bus.READ_DONE = rd_at_stop && (c == RD_C);
      if (abort_at >= 0) begin
        if (c == abort_at)     rst_n = 1'b0;
        if (c == abort_at + 2) rst_n = 1'b1;
        if (c == abort_at + 1) begin
          check("rst_mid.data", 32'(bus.RCV_DATAREG), 32'd0);
          check("rst_mid.ready", 32'(bus.DATA_READY), 32'd0);
          check("rst_mid.ferr", 32'(bus.ERR_FRAMING), 32'd0);
          check("rst_mid.oerr", 32'(bus.ERR_OVERRUN), 32'd0);
          check("rst_mid.busy", 32'(bus.BUSY), 32'd0);
        end
      end
      if (chk_busy) begin
        if (c == 80)        check("busy_mid", 32'(bus.BUSY), 32'd1);
        if (c == RD_C)      check("busy_pre_stop", 32'(bus.BUSY), 32'd1);
        if (c == RD_C + 2)  check("busy_post_stop", 32'(bus.BUSY), 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.READ_DONE = 1'b0;
    if (tail_low > 0) begin
      bus.SERIAL_IN = 1'b0;
      repeat (tail_low) @(posedge clk);
      #1;
    end
    bus.SERIAL_IN = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1;
    bus.READ_DONE = 1'b1;
    @(posedge clk); #1;
    bus.READ_DONE = 1'b0;
    model_read();
  endtask

  // Low glitch of 4 cycles, shorter than half a bit.
  task automatic glitch();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus.SERIAL_IN = (c < 4) ? 1'b0 : 1'b1;
      if (c == 5) check("glitch.busy_start", 32'(bus.BUSY), 32'd1);
    end
  endtask

  initial begin
    logic [WS-1:0] d;
    bit            sb;
    bit            rd;
    int            tail;

    bus.SERIAL_IN = 1'b1;
    bus.READ_DONE = 1'b0;
    model_reset();

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Good frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_model("good_a5");

    pulse_read();
    check_model("read_a5");

    // False start.
    glitch();
    check_model("false_start");

    // Framing error on 0x3C, line held low 40 cycles afterwards.
    send_frame(8'h3C, 1'b0, 1'b0, -1, 40, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_model("framing");
    pulse_read();
    check_model("framing_clr");

    // Overrun: 0x11 then 0x22 with no read.
    send_frame(8'h11, 1'b1, 1'b0, -1, 0, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, -1, 0, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    check_model("overrun");
    pulse_read();
    check_model("overrun_clr");

    // Read coinciding with the stop sample of 0x22 while 0x11 is pending.
    send_frame(8'h11, 1'b1, 1'b0, -1, 0, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, -1, 0, 1'b0);
    model_frame(8'h22, 1'b1, 1'b1);
    check_model("simul_read");

    // Reset during data bit 3 of 0xFF, then a clean 0x5A.
    send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB + 8, 0, 1'b0);
    model_reset();
    check_model("after_rst");
    send_frame(8'h5A, 1'b1, 1'b0, -1, 0, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b0);
    check_model("post_rst_5a");

    // Random frames against the model.
    for (int i = 0; i < 24; i++) begin
      d    = WS'($urandom);
      sb   = ($urandom_range(0, 4) != 0);
      rd   = sb && ($urandom_range(0, 2) == 0);
      tail = sb ? 0 : int'($urandom_range(0, 30));
      send_frame(d, sb, rd, -1, tail, 1'b0);
      model_frame(d, sb, rd);
      check_model($sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        pulse_read();
        check_model($sformatf("rand%0d_rd", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning CLOCK cycles per serial bit; legal values are even and >= 4.
REQ-003 SHALL have port CLOCK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port SERIAL_IN, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port READ_DONE, input, 1 bit: host acknowledge pulse; clears DATA_READY and ERR_OVERRUN.
REQ-007 SHALL have port RCV_DATAREG, output, WORD_SIZE bits: last good received word.
REQ-008 SHALL have port DATA_READY, output, 1 bit: RCV_DATAREG holds an unread word.
REQ-009 SHALL have port ERR_FRAMING, output, 1 bit: sticky flag; a stop bit was sampled low.
REQ-010 SHALL have port ERR_OVERRUN, output, 1 bit: sticky flag; a good frame completed while DATA_READY=1.
REQ-011 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL accept this frame format: one start bit (0), WORD_SIZE data bits LSB first, one stop bit (1); this matches the team's UART transmitter.
REQ-013 SHALL pass SERIAL_IN through a two-flop synchroniser; all decisions use the synchronised signal (rx_s).
REQ-014 SHALL implement four states IDLE, START, DATA, STOP, plus a bit-period counter and a data-bit counter.
REQ-015 IDLE: on an rx_s 1->0 transition, SHALL go to START with the bit counter cleared; otherwise SHALL stay in IDLE.
REQ-016 START: when the counter reaches CLKS_PER_BIT/2-1, SHALL sample rx_s; if 0, SHALL go to DATA with counter cleared; if 1, SHALL treat it as a false start and return to IDLE with no flags changed.
REQ-017 DATA: at each counter value CLKS_PER_BIT-1, SHALL sample rx_s, right-shift it into the shift register MSB, and clear the counter; after the WORD_SIZE-th sample SHALL go to STOP.
REQ-018 STOP: at counter CLKS_PER_BIT-1, SHALL sample rx_s and return to IDLE on the next cycle.
REQ-019 At the stop sample, if rx_s=1 and DATA_READY=0, SHALL load RCV_DATAREG and set DATA_READY on the following clock edge.
REQ-020 At the stop sample, if rx_s=1 and DATA_READY=1 with READ_DONE=0, SHALL discard the new word, keep RCV_DATAREG unchanged, and set ERR_OVERRUN.
REQ-021 At the stop sample, if rx_s=0, SHALL set ERR_FRAMING, discard the word, and leave DATA_READY unchanged.
REQ-022 After a framing error, IDLE SHALL require rx_s to return high before a new start edge is recognised, so that a break condition does not retrigger.
REQ-023 READ_DONE=1 SHALL clear DATA_READY, ERR_OVERRUN and ERR_FRAMING on the next edge.
REQ-024 When READ_DONE coincides with a good stop sample, SHALL load the new word, hold DATA_READY=1, and not set ERR_OVERRUN.
REQ-025 Reception SHALL be independent of READ_DONE; a frame in progress is never aborted by the host.
REQ-026 Counters SHALL be sized to hold CLKS_PER_BIT-1 and WORD_SIZE respectively, and SHALL never wrap during a frame.

Reset
REQ-027 With RESET=0 at a clock edge, SHALL set state=IDLE, clear all counters and the shift register, set RCV_DATAREG=0, set DATA_READY, ERR_FRAMING, ERR_OVERRUN and BUSY to 0, and set both synchroniser flops to 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the receiver SHALL wait for a fresh 1->0 edge.

Verification
REQ-029 Good frame: CLKS_PER_BIT=16, send 0xA5 -> RCV_DATAREG=0xA5, DATA_READY=1, flags 0, BUSY low about 8 cycles after the stop-bit start.
REQ-030 False start: low glitch of 4 cycles -> receiver returns to IDLE, DATA_READY=0, no flags set.
REQ-031 Framing error: send 0x3C with stop bit 0 -> ERR_FRAMING=1, DATA_READY=0, RCV_DATAREG unchanged; line held low 40 cycles gives no second frame.
REQ-032 Overrun: send 0x11 then 0x22 with no READ_DONE -> RCV_DATAREG=0x11, ERR_OVERRUN=1; then pulse READ_DONE -> DATA_READY=0 and ERR_OVERRUN=0.
REQ-033 Simultaneous read: READ_DONE pulsed on the stop-sample cycle of 0x22 while 0x11 is pending -> RCV_DATAREG=0x22, DATA_READY=1, ERR_OVERRUN=0.
REQ-034 Reset mid-frame: assert RESET=0 during data bit 3 of 0xFF -> all outputs 0; the next clean frame 0x5A is received correctly.
